// File: rtl/router_nic_port.sv
// Router-side local port of the NIC<->router link: per-VC one-entry inject and
// eject buffers, with even/odd VCs alternating between link and crossbar access.
module router_nic_port #(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          net_polarity,
  input  logic          net_so,
  output logic          net_ro,
  input  logic [DW-1:0] net_do,
  output logic          net_si,
  input  logic          net_ri,
  output logic [DW-1:0] net_di,
  output logic          inj_valid,
  input  logic          inj_ready,
  output logic [DW-1:0] inj_data,
  input  logic          ej_valid,
  output logic          ej_ready,
  input  logic [DW-1:0] ej_data,
  output logic [CW-1:0] inj_cnt,
  output logic [CW-1:0] ej_cnt,
  output logic          vc_err
);

  logic          polarity;
  logic          link_vc;
  logic          xbar_vc;
  logic [1:0]    inj_full;
  logic [1:0]    ej_full;
  logic [DW-1:0] inj_buf [2];
  logic [DW-1:0] ej_buf  [2];

  logic inj_take;
  logic inj_wr;
  logic inj_bad;
  logic inj_pop;
  logic ej_take;
  logic ej_wr;
  logic ej_bad;
  logic ej_pop;

  // Link side owns VC == polarity, crossbar side owns the other one, so no
  // buffer is ever read and written by both sides in the same cycle.
  assign link_vc = polarity;
  assign xbar_vc = ~polarity;

  assign net_polarity = polarity;

  always_comb begin
    net_ro    = ~inj_full[link_vc];
    inj_valid = inj_full[xbar_vc];
    inj_data  = inj_buf[xbar_vc];
    ej_ready  = ~ej_full[xbar_vc];
    net_si    = ej_full[link_vc] & net_ri;
    net_di    = '0;
    if (net_si) begin
      net_di = ej_buf[link_vc];
    end
  end

  always_comb begin
    inj_take = net_so & net_ro;
    inj_wr   = inj_take & (net_do[DW-1] == link_vc);
    inj_bad  = inj_take & (net_do[DW-1] != link_vc);
    inj_pop  = inj_valid & inj_ready;
    ej_take  = ej_valid & ej_ready;
    ej_wr    = ej_take & (ej_data[DW-1] == xbar_vc);
    ej_bad   = ej_take & (ej_data[DW-1] != xbar_vc);
    ej_pop   = net_si;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      polarity <= 1'b0;
      inj_full <= '0;
      ej_full  <= '0;
      inj_cnt  <= '0;
      ej_cnt   <= '0;
      vc_err   <= 1'b0;
    end else begin
      polarity <= ~polarity;
      if (inj_wr) begin
        inj_full[link_vc] <= 1'b1;
        inj_cnt           <= inj_cnt + CW'(1);
      end
      if (inj_pop) begin
        inj_full[xbar_vc] <= 1'b0;
      end
      if (ej_wr) begin
        ej_full[xbar_vc] <= 1'b1;
      end
      if (ej_pop) begin
        ej_full[link_vc] <= 1'b0;
        ej_cnt           <= ej_cnt + CW'(1);
      end
      if (inj_bad || ej_bad) begin
        vc_err <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the full bits qualify it.
  always_ff @(posedge clk) begin
    if (inj_wr) begin
      inj_buf[link_vc] <= net_do;
    end
    if (ej_wr) begin
      ej_buf[xbar_vc] <= ej_data;
    end
  end

endmodule
